// File: rtl/dir_button_conditioner_if.sv
// Raw direction buttons plus move handshake in, one-hot move pulses and status out.
// master drives buttons/move_ready (board side); slave is the conditioner.
interface dir_button_conditioner_if;
  logic BtnU;
  logic BtnD;
  logic BtnL;
  logic BtnR;
  logic move_ready;
  logic up;
  logic down;
  logic left;
  logic right;
  logic pending;
  logic overrun;

  modport master (
    output BtnU, BtnD, BtnL, BtnR, move_ready,
    input  up, down, left, right, pending, overrun
  );

  modport slave (
    input  BtnU, BtnD, BtnL, BtnR, move_ready,
    output up, down, left, right, pending, overrun
  );
endinterface

// File: rtl/dir_button_conditioner.sv
// Sync + debounce four buttons into one-hot registered move pulses, DEBOUNCE_CYCLES+3 latency;
// one pending move waits for move_ready, further presses raise overrun. AUTO_REPEAT_EN adds held repeat.
module dir_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int CNT_W           = 26
) (
  input logic                      Clk,
  input logic                      Reset,
  dir_button_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} deb_state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("dir_button_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  // bit order everywhere: 0=U, 1=D, 2=L, 3=R (also the priority order)
  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] press_evt;

  assign raw = {bus.BtnR, bus.BtnL, bus.BtnD, bus.BtnU};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             evt;
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RLAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        state <= IDLE;
        cnt   <= '0;
        evt   <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt  <= '0;
`endif
      end else begin
        evt <= 1'b0;
        case (state)
          IDLE: if (sync2[i]) begin
            state <= DEB_PRESS;
            cnt   <= ONE;
          end
          DEB_PRESS: if (!sync2[i]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= HELD;
            cnt   <= '0;
            evt   <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
          HELD: if (!sync2[i]) begin
            state <= DEB_REL;
            cnt   <= ONE;
`ifdef AUTO_REPEAT_EN
            rcnt  <= '0;
          end else if (rcnt == RLAST) begin
            rcnt <= '0;
            evt  <= 1'b1;
          end else begin
            rcnt <= rcnt + ONE;
`endif
          end
          DEB_REL: if (sync2[i]) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign press_evt[i] = evt;
  end

  logic [3:0] win_oh;
  logic       cand_vld;
  logic [1:0] cand_dir;
  logic       lost;

  always_comb begin
    win_oh   = press_evt & (~press_evt + 4'd1);
    cand_vld = |press_evt;
    lost     = |(press_evt & ~win_oh);
    cand_dir = 2'd0;
    case (win_oh)
      4'b0010: cand_dir = 2'd1;
      4'b0100: cand_dir = 2'd2;
      4'b1000: cand_dir = 2'd3;
      default: cand_dir = 2'd0;
    endcase
  end

  logic       slot_vld;
  logic [1:0] slot_dir;
  logic       fire;
  logic       load_ok;
  logic       up_q, down_q, left_q, right_q, overrun_q;

  // a release on the same edge frees the slot for the incoming candidate
  assign fire    = slot_vld & bus.move_ready;
  assign load_ok = cand_vld & (~slot_vld | bus.move_ready);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      slot_vld  <= 1'b0;
      slot_dir  <= 2'd0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      up_q      <= fire & (slot_dir == 2'd0);
      down_q    <= fire & (slot_dir == 2'd1);
      left_q    <= fire & (slot_dir == 2'd2);
      right_q   <= fire & (slot_dir == 2'd3);
      overrun_q <= lost | (cand_vld & ~load_ok);
      if (load_ok) begin
        slot_vld <= 1'b1;
        slot_dir <= cand_dir;
      end else if (fire) begin
        slot_vld <= 1'b0;
      end
    end
  end

  assign bus.up      = up_q;
  assign bus.down    = down_q;
  assign bus.left    = left_q;
  assign bus.right   = right_q;
  assign bus.pending = slot_vld;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_dir_button_conditioner.sv
// Directed bench for dir_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Table of single-press vectors plus hand sequences for glitch, stall, reset and repeat.
module tb_dir_button_conditioner;
  localparam int D = 4;
  localparam int R = 10;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;

  dir_button_conditioner_if bus();

  dir_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .CNT_W          (8)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int n_pulse [4];
  int first_off [4];
  int last_off [4];
  int n_ovr, first_ovr, n_pend, onehot_err, base;
  bit mon_en = 1'b0;

  always @(negedge Clk) begin
    if (mon_en) begin
      int off;
      logic [3:0] d;
      off = cyc - base;
      d = {bus.right, bus.left, bus.down, bus.up};
      for (int k = 0; k < 4; k++) begin
        if (d[k]) begin
          n_pulse[k]++;
          last_off[k] = off;
          if (first_off[k] < 0) first_off[k] = off;
        end
      end
      if ($countones(d) > 1) onehot_err++;
      if (bus.overrun) begin
        n_ovr++;
        if (first_ovr < 0) first_ovr = off;
      end
      if (bus.pending) n_pend++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) begin
      n_pulse[k]   = 0;
      first_off[k] = -1;
      last_off[k]  = -1;
    end
    n_ovr      = 0;
    first_ovr  = -1;
    n_pend     = 0;
    onehot_err = 0;
    base       = cyc + 1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.BtnU = b[0];
    bus.BtnD = b[1];
    bus.BtnL = b[2];
    bus.BtnR = b[3];
  endtask

  typedef struct {
    logic [3:0] btn;
    int         hold;
    int         exp_dir;
    int         exp_ovr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{4'b0001, 50, 0, 0};
    vecs[1] = '{4'b0010, 20, 1, 0};
    vecs[2] = '{4'b0100, 20, 2, 0};
    vecs[3] = '{4'b1000, 20, 3, 0};
    vecs[4] = '{4'b0101, 20, 0, 1};
    vecs[5] = '{4'b1010, 20, 1, 1};
    vecs[6] = '{4'b1100, 20, 2, 1};

    Reset = 1'b0;
    set_btn(4'b0000);
    bus.move_ready = 1'b1;
    clr();
    tick(3);
    check("reset_outputs", int'({bus.up, bus.down, bus.left, bus.right, bus.pending, bus.overrun}), 0);
    Reset = 1'b1;
    tick(3);

    // single and simultaneous presses, move_ready high
    for (int v = 0; v < 7; v++) begin
      int others;
      clr();
      mon_en = 1'b1;
      set_btn(vecs[v].btn);
      tick(vecs[v].hold);
      set_btn(4'b0000);
      tick(D + 10);
      mon_en = 1'b0;
      others = n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3] - n_pulse[vecs[v].exp_dir];
      check($sformatf("vec%0d_pulse_count", v), n_pulse[vecs[v].exp_dir], 1);
      check($sformatf("vec%0d_pulse_offset", v), first_off[vecs[v].exp_dir], D + 3);
      check($sformatf("vec%0d_other_pulses", v), others, 0);
      check($sformatf("vec%0d_overrun_count", v), n_ovr, vecs[v].exp_ovr);
      if (vecs[v].exp_ovr != 0)
        check($sformatf("vec%0d_overrun_offset", v), first_ovr, D + 2);
      check($sformatf("vec%0d_pending_cycles", v), n_pend, 1);
      check($sformatf("vec%0d_onehot", v), onehot_err, 0);
    end

    // bounce never stable for D cycles
    clr();
    mon_en = 1'b1;
    bus.BtnL = 1'b1; tick(3);
    bus.BtnL = 1'b0; tick(2);
    bus.BtnL = 1'b1; tick(3);
    bus.BtnL = 1'b0; tick(20);
    mon_en = 1'b0;
    check("glitch_pulses", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 0);
    check("glitch_pending", n_pend, 0);
    check("glitch_overrun", n_ovr, 0);

    // stalled FSM: slot holds, extra press overruns, release on move_ready
    bus.move_ready = 1'b0;
    clr();
    mon_en = 1'b1;
    bus.BtnD = 1'b1;
    tick(D + 6);
    check("stall_pending_set", int'(bus.pending), 1);
    clr();
    tick(100);
    check("stall_pending_held", n_pend, 100);
    check("stall_no_down", n_pulse[1], 0);
    clr();
    bus.BtnU = 1'b1;
    tick(D + 8);
    set_btn(4'b0000);
    tick(D + 8);
    check("full_slot_overrun", n_ovr, 1);
    check("full_slot_no_pulse", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 0);
    check("full_slot_pending", n_pend, 2 * D + 16);
    clr();
    bus.move_ready = 1'b1;
    tick(5);
    check("release_down_count", n_pulse[1], 1);
    check("release_down_offset", first_off[1], 0);
    check("release_not_up", n_pulse[0], 0);
    check("release_pending_low", n_pend, 0);
    mon_en = 1'b0;

    // asynchronous reset in the middle of a debounce
    bus.move_ready = 1'b0;
    bus.BtnD = 1'b1;
    tick(D + 6);
    bus.BtnD = 1'b0;
    tick(D + 8);
    check("pre_reset_pending", int'(bus.pending), 1);
    bus.BtnR = 1'b1;
    tick(4);
    Reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({bus.up, bus.down, bus.left, bus.right, bus.pending, bus.overrun}), 0);
    tick(2);
    bus.move_ready = 1'b1;
    Reset = 1'b1;
    clr();
    mon_en = 1'b1;
    tick(D + 10);
    bus.BtnR = 1'b0;
    tick(D + 8);
    mon_en = 1'b0;
    check("post_reset_right_count", n_pulse[3], 1);
    check("post_reset_right_offset", first_off[3], D + 3);
    check("post_reset_no_down", n_pulse[1], 0);

    // long hold: repeat pulses only with the auto-repeat build
    clr();
    mon_en = 1'b1;
    bus.BtnU = 1'b1;
    tick(40);
    bus.BtnU = 1'b0;
    tick(D + 10);
    mon_en = 1'b0;
    check("hold_first_offset", first_off[0], D + 3);
    check("hold_overrun", n_ovr, 0);
`ifdef AUTO_REPEAT_EN
    check("hold_repeat_count", n_pulse[0], 4);
    check("hold_last_offset", last_off[0], D + 3 + 3 * R);
`else
    check("hold_single_count", n_pulse[0], 1);
    check("hold_last_offset", last_off[0], D + 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
